dmem_wait_ctrl: RTL and testbench
=================================

Name: dmem_wait_ctrl

Overview:
- Data-memory slave that sits directly downstream of top_proc's data port.
- Consumes MemRead/MemWrite/dAddress/dWriteData and produces dReadData plus a ready/error handshake back to the processor's MEM state.
- Holds a word-organised RAM behind a programmable wait-state FSM, so the multicycle core can be exercised against non-zero memory latency.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words in the array (power of two, >=4)
- WAIT_STATES, 1, extra cycles between request accept and response (0..15)
- BASE_ADDR, 32'h0000_0000, byte address of word 0 (DEPTH_WORDS*4 aligned)

Ports:
- clk  in  1  system clock, rising-edge
- rst  in  1  synchronous, active-high reset
- MemRead  in  1  read request from processor
- MemWrite  in  1  write request from processor
- dAddress  in  32  byte address
- dWriteData  in  32  store data
- dReadData  out  32  load data, registered
- mem_ready  out  1  one-cycle completion pulse
- mem_err  out  1  one-cycle error pulse, coincident with mem_ready

Behaviour:
- Reset and clocking
  - One clock; reset is synchronous and active-high, ports named clk and rst.
  - Reset values: dReadData=0, mem_ready=0, mem_err=0, state=IDLE, wait counter=0, req_q=0.
  - The RAM array is not cleared by reset.
- Request detection
  - req = MemRead | MemWrite; req_q is req registered.
  - A request is accepted only in IDLE on a rising edge (req & ~req_q). A level held high after completion is never re-accepted.
  - On acceptance, latch into internal registers: dAddress, dWriteData, op (read/write), err_flag.
- Error conditions (err_flag)
  - MemRead and MemWrite both high.
  - dAddress[1:0] != 0.
  - dAddress outside [BASE_ADDR, BASE_ADDR+4*DEPTH_WORDS-1].
  - Word index = (addr-BASE_ADDR)>>2, log2(DEPTH_WORDS) bits.
- FSM states: IDLE, WAIT, RESP
  - IDLE -> WAIT on accept when WAIT_STATES>0 (counter loaded WAIT_STATES-1).
  - IDLE -> RESP on accept when WAIT_STATES==0.
  - WAIT: counter decrements each cycle; -> RESP when counter==0.
  - RESP -> IDLE unconditionally after one cycle.
- Latency and response
  - Accept edge at cycle T; mem_ready high during cycle T+WAIT_STATES+1, exactly one cycle.
  - RAM write and dReadData update happen on the clock edge entering RESP.
  - Write (no error): RAM[index] <= latched data; dReadData unchanged.
  - Read (no error): dReadData <= RAM[index]. It holds that value until the next successful read completes.
  - Any error: no RAM write; dReadData <= 0; mem_err=1 with mem_ready=1.
- Boundary conditions
  - Inputs changing after acceptance are ignored (latched copies used).
  - req rising during WAIT/RESP is ignored. Because req_q tracks it, the processor must drop and re-raise req to issue a new access.
  - rst during WAIT or RESP aborts: no RAM write, outputs return to reset values next edge.
  - Highest word (index DEPTH_WORDS-1) is valid; next word address is an error (no wrap-around).

Decomposition:
- Shared package dmem_pkg:
  - state encoding localparams (IDLE=2'd0, WAIT=2'd1, RESP=2'd2)
  - width helper function clog2
  - WORD_BYTES=4
- One sub-module, dmem_ram_array: single-port synchronous RAM with we, index, wdata, rdata, parameterised by DEPTH_WORDS.
- FSM, counter, address decode and error logic stay in dmem_wait_ctrl.

Test Plan:
- Reset sequence, WAIT_STATES=1: hold rst 2 cycles -> dReadData=0, mem_ready=0, mem_err=0 after first edge.
- Write 32'hDEADBEEF to 0x10 with WAIT_STATES=2, then read 0x10:
  - write: mem_ready exactly 3 cycles after accept, mem_err=0.
  - read: dReadData=32'hDEADBEEF at its mem_ready.
- Misaligned read 0x13 and out-of-range write 0x400 (DEPTH_WORDS=256):
  - each: mem_ready=1 and mem_err=1 together, dReadData=0.
  - re-read of 0x3FC shows it unmodified.
- MemRead=MemWrite=1 at 0x20 -> mem_err pulse, RAM[8] unchanged.
- Hold MemRead high 10 cycles at 0x10 -> exactly one mem_ready pulse; drop then re-raise -> second pulse.
- Assert rst in WAIT of a write of 32'h12345678 to 0x30 -> no mem_ready; subsequent read of 0x30 returns the pre-write value.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the wait-stated data memory slave.
package dmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam int WORD_BYTES = 4;

  function automatic int clog2(input int value);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'd1 << i) < 32'(value)) begin
        w = i + 1;
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/dmem_ram_array.sv
// Word-wide single-port RAM: synchronous write, combinational read of the addressed word.
module dmem_ram_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int IDX_W       = clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [IDX_W-1:0] index_i,
  input  logic [31:0]      wdata_i,
  output logic [31:0]      rdata_o
);

  logic [31:0] mem_q [DEPTH_WORDS];

  // Array write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[index_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[index_i];

endmodule

// File: rtl/dmem_wait_ctrl.sv
// Data-memory slave with a programmable wait-state FSM between request accept and
// the one-cycle ready/error response.
module dmem_wait_ctrl
  import dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 256,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] dAddress,
  input  logic [31:0] dWriteData,
  output logic [31:0] dReadData,
  output logic        mem_ready,
  output logic        mem_err
);

  localparam int IDX_W = clog2(DEPTH_WORDS);

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             req_s, req_q, accept_s, enter_resp_s;
  logic [31:0]      offset_s;
  logic             in_range_s, err_s, write_s;
  logic [IDX_W-1:0] idx_s, idx_q, eff_idx_s;
  logic [31:0]      wdata_q, eff_wdata_s;
  logic             write_q, eff_write_s, err_q, eff_err_s;
  logic             ram_we_s;
  logic [31:0]      ram_rdata_s;
  logic [31:0]      rdata_q, rdata_d;
  logic             ready_q, err_out_q;

  assign req_s    = MemRead | MemWrite;
  assign accept_s = (state_q == ST_IDLE) & req_s & ~req_q;

  // Base is aligned to the array size, so anything above the index bits must be zero.
  assign offset_s   = dAddress - BASE_ADDR;
  assign idx_s      = offset_s[IDX_W+1:2];
  assign in_range_s = (dAddress >= BASE_ADDR) && ((offset_s >> (IDX_W + 2)) == 32'd0);
  assign err_s      = (MemRead & MemWrite) | (dAddress[1:0] != 2'b00) | ~in_range_s;
  assign write_s    = MemWrite & ~MemRead;

  // Zero-wait accesses enter RESP straight from IDLE, so they must use live inputs.
  always_comb begin
    eff_idx_s   = idx_q;
    eff_wdata_s = wdata_q;
    eff_write_s = write_q;
    eff_err_s   = err_q;
    if (state_q == ST_IDLE) begin
      eff_idx_s   = idx_s;
      eff_wdata_s = dWriteData;
      eff_write_s = write_s;
      eff_err_s   = err_s;
    end else begin
      eff_idx_s   = idx_q;
      eff_wdata_s = wdata_q;
      eff_write_s = write_q;
      eff_err_s   = err_q;
    end
  end

  // Next-state and wait counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          if (WAIT_STATES > 32'sd0) begin
            state_d = ST_WAIT;
            cnt_d   = 4'(WAIT_STATES - 1);
          end else begin
            state_d = ST_RESP;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  assign enter_resp_s = (state_d == ST_RESP);
  assign ram_we_s     = enter_resp_s & eff_write_s & ~eff_err_s & ~rst;

  // Load data is only replaced by a successful read or cleared by an error.
  always_comb begin
    rdata_d = rdata_q;
    if (enter_resp_s) begin
      if (eff_err_s) begin
        rdata_d = 32'h0000_0000;
      end else if (!eff_write_s) begin
        rdata_d = ram_rdata_s;
      end else begin
        rdata_d = rdata_q;
      end
    end else begin
      rdata_d = rdata_q;
    end
  end

  // State, handshake and request latches.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      req_q     <= 1'b0;
      idx_q     <= '0;
      wdata_q   <= 32'h0000_0000;
      write_q   <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= 32'h0000_0000;
      ready_q   <= 1'b0;
      err_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      req_q     <= req_s;
      rdata_q   <= rdata_d;
      ready_q   <= enter_resp_s;
      err_out_q <= enter_resp_s & eff_err_s;
      if (accept_s) begin
        idx_q   <= idx_s;
        wdata_q <= dWriteData;
        write_q <= write_s;
        err_q   <= err_s;
      end
    end
  end

  dmem_ram_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we_s),
    .index_i (eff_idx_s),
    .wdata_i (eff_wdata_s),
    .rdata_o (ram_rdata_s)
  );

  assign dReadData = rdata_q;
  assign mem_ready = ready_q;
  assign mem_err   = err_out_q;

endmodule

// File: tb/tb_dmem_wait_ctrl.sv
// Self-checking bench for dmem_wait_ctrl: directed table, multi-cycle corner cases,
// and randomized accesses against a word-array reference model.
module tb_dmem_wait_ctrl;

  localparam int          DEPTH = 256;
  localparam int          WS    = 2;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic        clk, rst, MemRead, MemWrite;
  logic [31:0] dAddress, dWriteData, dReadData;
  logic        mem_ready, mem_err;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] mem_m [DEPTH];
  logic [31:0] rd_m;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t tbl [11];

  dmem_wait_ctrl #(
    .DEPTH_WORDS (DEPTH),
    .WAIT_STATES (WS),
    .BASE_ADDR   (BASE)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .dAddress   (dAddress),
    .dWriteData (dWriteData),
    .dReadData  (dReadData),
    .mem_ready  (mem_ready),
    .mem_err    (mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] pat(input int i);
    return 32'h5A5A_0000 ^ (32'(i) * 32'h0001_0003);
  endfunction

  // Reference: error rules, word array and last successful load value.
  function automatic void model_step(input logic rd, input logic wr, input logic [31:0] a,
                                     input logic [31:0] wd, output logic e, output logic [31:0] r);
    longint unsigned la, lo, hi;
    int idx;
    la = longint'(a);
    lo = longint'(BASE);
    hi = lo + longint'(DEPTH) * 4;
    e  = (rd && wr) || (a % 4 != 0) || (la < lo) || (la >= hi);
    idx = int'((la - lo) / 4);
    if (e) begin
      rd_m = 32'h0;
    end else if (wr) begin
      mem_m[idx] = wd;
    end else begin
      rd_m = mem_m[idx];
    end
    r = rd_m;
  endfunction

  // One bus access: raise request, wait for ready, check latency and pulse width, drop request.
  task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wd, input string nm,
                        output logic err_o, output logic [31:0] rdata_o);
    int cyc;
    logic got;
    @(negedge clk);
    MemRead = rd; MemWrite = wr; dAddress = addr; dWriteData = wd;
    cyc = 0; got = 1'b0;
    while (!got && cyc < 40) begin
      @(negedge clk);
      cyc++;
      got = mem_ready;
    end
    chk({nm, " latency"}, 32'(cyc), 32'(WS + 1));
    err_o = mem_err;
    rdata_o = dReadData;
    MemRead = 1'b0; MemWrite = 1'b0;
    @(negedge clk);
    chk({nm, " ready width"}, {31'd0, mem_ready}, 32'd0);
    chk({nm, " err width"}, {31'd0, mem_err}, 32'd0);
  endtask

  task automatic run_model(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wd, input string nm);
    logic e, ee;
    logic [31:0] r, er;
    access(rd, wr, addr, wd, nm, e, r);
    model_step(rd, wr, addr, wd, ee, er);
    chk({nm, " err"}, {31'd0, e}, {31'd0, ee});
    chk({nm, " rdata"}, r, er);
  endtask

  initial begin
    logic e, ee;
    logic [31:0] r, er, cap;
    int pulses;
    int cyc;
    logic got;

    rst = 1'b1; MemRead = 1'b0; MemWrite = 1'b0;
    dAddress = 32'h0; dWriteData = 32'h0;
    rd_m = 32'h0;

    // Reset: outputs clear after the first edge and stay clear
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("reset dReadData", dReadData, 32'h0);
      chk("reset mem_ready", {31'd0, mem_ready}, 32'd0);
      chk("reset mem_err", {31'd0, mem_err}, 32'd0);
    end
    rst = 1'b0;

    for (int i = 0; i < DEPTH; i++) begin
      run_model(1'b0, 1'b1, BASE + 32'(i * 4), pat(i), "init write");
    end

    tbl[0]  = '{1'b0, 1'b1, 32'h010, 32'hDEADBEEF, 1'b0, 32'h0};
    tbl[1]  = '{1'b1, 1'b0, 32'h010, 32'h0,        1'b0, 32'hDEADBEEF};
    tbl[2]  = '{1'b1, 1'b0, 32'h013, 32'h0,        1'b1, 32'h0};
    tbl[3]  = '{1'b0, 1'b1, 32'h400, 32'h11111111, 1'b1, 32'h0};
    tbl[4]  = '{1'b1, 1'b0, 32'h3FC, 32'h0,        1'b0, pat(255)};
    tbl[5]  = '{1'b1, 1'b1, 32'h020, 32'h0BADF00D, 1'b1, 32'h0};
    tbl[6]  = '{1'b1, 1'b0, 32'h020, 32'h0,        1'b0, pat(8)};
    tbl[7]  = '{1'b0, 1'b1, 32'h3FC, 32'hCAFEF00D, 1'b0, pat(8)};
    tbl[8]  = '{1'b1, 1'b0, 32'h3FC, 32'h0,        1'b0, 32'hCAFEF00D};
    tbl[9]  = '{1'b1, 1'b0, 32'h400, 32'h0,        1'b1, 32'h0};
    tbl[10] = '{1'b1, 1'b0, 32'h000, 32'h0,        1'b0, pat(0)};

    for (int i = 0; i < 11; i++) begin
      access(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata, $sformatf("tbl%0d", i), e, r);
      model_step(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata, ee, er);
      chk($sformatf("tbl%0d err", i), {31'd0, e}, {31'd0, tbl[i].exp_err});
      chk($sformatf("tbl%0d rdata", i), r, tbl[i].exp_rdata);
    end

    // Level held high: one response only, then drop and re-raise for a second
    for (int pass = 0; pass < 2; pass++) begin
      @(negedge clk);
      MemRead = 1'b1; MemWrite = 1'b0; dAddress = 32'h10;
      pulses = 0; cap = 32'h0;
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        if (mem_ready) begin
          pulses++;
          cap = dReadData;
        end
      end
      model_step(1'b1, 1'b0, 32'h10, 32'h0, ee, er);
      chk($sformatf("level pulses %0d", pass), 32'(pulses), 32'd1);
      chk($sformatf("level rdata %0d", pass), cap, er);
      MemRead = 1'b0;
    end
    @(negedge clk);

    // Inputs changed after acceptance are ignored
    @(negedge clk);
    MemWrite = 1'b1; MemRead = 1'b0; dAddress = 32'h40; dWriteData = 32'h0F0F0F0F;
    @(negedge clk);
    MemRead = 1'b1; dAddress = 32'h44; dWriteData = 32'hF0F0F0F0;
    cyc = 1; got = mem_ready;
    while (!got && cyc < 40) begin
      @(negedge clk);
      cyc++;
      got = mem_ready;
    end
    chk("latched latency", 32'(cyc), 32'(WS + 1));
    chk("latched err", {31'd0, mem_err}, 32'd0);
    MemRead = 1'b0; MemWrite = 1'b0;
    @(negedge clk);
    model_step(1'b0, 1'b1, 32'h40, 32'h0F0F0F0F, ee, er);
    run_model(1'b1, 1'b0, 32'h40, 32'h0, "latched rd40");
    run_model(1'b1, 1'b0, 32'h44, 32'h0, "latched rd44");

    // Reset during WAIT (mid and on the edge that would enter RESP) aborts the write
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      MemWrite = 1'b1; dAddress = 32'h30 + 32'((k - 1) * 4); dWriteData = 32'h12345678;
      repeat (k) @(negedge clk);
      rst = 1'b1; MemWrite = 1'b0;
      @(negedge clk);
      chk($sformatf("abort%0d ready", k), {31'd0, mem_ready}, 32'd0);
      chk($sformatf("abort%0d err", k), {31'd0, mem_err}, 32'd0);
      chk($sformatf("abort%0d rdata", k), dReadData, 32'h0);
      rst = 1'b0; rd_m = 32'h0;
      pulses = 0;
      for (int c = 0; c < 5; c++) begin
        @(negedge clk);
        if (mem_ready) pulses++;
      end
      chk($sformatf("abort%0d pulses", k), 32'(pulses), 32'd0);
      run_model(1'b1, 1'b0, 32'h30 + 32'((k - 1) * 4), 32'h0, $sformatf("abort%0d reread", k));
    end

    // Randomized accesses against the reference model
    for (int n = 0; n < 200; n++) begin
      int ka, ko;
      logic [31:0] a;
      logic rd, wr;
      ka = $urandom_range(0, 9);
      if (ka < 7)       a = BASE + (32'($urandom_range(0, DEPTH - 1)) << 2);
      else if (ka == 7) a = BASE + (32'($urandom_range(0, DEPTH - 1)) << 2) + 32'($urandom_range(1, 3));
      else if (ka == 8) a = BASE + 32'(DEPTH * 4) + (32'($urandom_range(0, 15)) << 2);
      else              a = $urandom;
      ko = $urandom_range(0, 9);
      rd = (ko < 4) || (ko == 9);
      wr = (ko >= 4);
      run_model(rd, wr, a, $urandom, $sformatf("rand%0d", n));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
